// File: rtl/pc_next_ctrl.sv
// Next-PC sequencer: picks sequential fetch, branch redirect, trap entry or mret return.
// Latency: pc_next and control outputs are combinational; epc/mtvec/state/pend_pc update on clk.
// Backpressure: imem_ready=0 or hazard_stall holds the PC; a redirect seen while not ready is parked in pend_pc.
module pc_next_ctrl #(
    parameter int                  PC_WIDTH     = 64,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 64'h0000_0000_8000_0000,
    parameter logic [PC_WIDTH-1:0] MTVEC_RESET  = 64'h0000_0000_0000_0100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pc_cur,
    input  logic                hazard_stall,
    input  logic                imem_ready,
    input  logic                br_valid,
    input  logic [PC_WIDTH-1:0] br_pc,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                trap_valid,
    input  logic [PC_WIDTH-1:0] trap_pc,
    input  logic                mret_valid,
    input  logic                mtvec_we,
    input  logic [PC_WIDTH-1:0] mtvec_wdata,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                pc_stall,
    output logic                flush_if_id,
    output logic                flush_id_ex,
    output logic                fetch_valid,
    output logic                trap_taken,
    output logic [1:0]          trap_cause,
    output logic [PC_WIDTH-1:0] epc,
    output logic [PC_WIDTH-1:0] mtvec
);

    // BOOT issues the reset vector once; PEND parks a redirect until imem accepts.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Winning redirect source for this cycle, in priority order.
    typedef enum logic [2:0] {
        SRC_NONE     = 3'd0,
        SRC_TRAP     = 3'd1,
        SRC_MRET     = 3'd2,
        SRC_MISALIGN = 3'd3,
        SRC_BRANCH   = 3'd4
    } src_t;

    state_t              state;
    state_t              state_nxt;
    src_t                src;
    logic [PC_WIDTH-1:0] pend_pc;
    logic [PC_WIDTH-1:0] pend_pc_nxt;
    logic [PC_WIDTH-1:0] redir_target;
    logic [PC_WIDTH-1:0] seq_pc;
    logic                redirect;
    logic                br_misaligned;

    assign br_misaligned = |br_target[1:0];
    assign seq_pc        = pc_cur + PC_WIDTH'(4);
    assign redirect      = (src != SRC_NONE);

    // Priority-encode redirect requests; BOOT ignores them all.
    always_comb begin
        src = SRC_NONE;
        if (state != ST_BOOT) begin
            if (trap_valid) begin
                src = SRC_TRAP;
            end else if (mret_valid) begin
                src = SRC_MRET;
            end else if (br_valid && br_misaligned) begin
                src = SRC_MISALIGN;
            end else if (br_valid) begin
                src = SRC_BRANCH;
            end
        end
    end

    // Resolve the target; trap/mret use the pre-edge mtvec/epc so same-cycle writes are not seen.
    always_comb begin
        redir_target = pc_cur;
        case (src)
            SRC_TRAP,
            SRC_MISALIGN: redir_target = mtvec;
            SRC_MRET:     redir_target = epc;
            SRC_BRANCH:   redir_target = br_target;
            default:      redir_target = pc_cur;
        endcase
    end

    // Flushes and trap reporting depend only on the winning source, not on stalls.
    always_comb begin
        flush_if_id = redirect;
        flush_id_ex = redirect;
        trap_taken  = (src == SRC_TRAP) || (src == SRC_MISALIGN);
        trap_cause  = {1'b0, (src == SRC_MISALIGN)};
    end

    // Next-state and PC-register control.
    always_comb begin
        state_nxt   = state;
        pend_pc_nxt = pend_pc;
        pc_next     = pc_cur;
        pc_stall    = 1'b1;
        fetch_valid = 1'b0;
        case (state)
            ST_BOOT: begin
                pc_next   = RESET_VECTOR;
                pc_stall  = 1'b0;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                fetch_valid = 1'b1;
                if (redirect) begin
                    if (imem_ready) begin
                        pc_next  = redir_target;
                        pc_stall = 1'b0;
                    end else begin
                        pend_pc_nxt = redir_target;
                        state_nxt   = ST_PEND;
                    end
                end else if (!hazard_stall && imem_ready) begin
                    pc_next  = seq_pc;
                    pc_stall = 1'b0;
                end
            end
            ST_PEND: begin
                // Pipeline is already flushed, so hazard_stall has no meaning here.
                if (redirect) begin
                    pend_pc_nxt = redir_target;
                end
                if (imem_ready) begin
                    pc_next   = redirect ? redir_target : pend_pc;
                    pc_stall  = 1'b0;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // FSM state and parked redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_BOOT;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    // Exception PC captured on trap entry; misaligned branches record the branch PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc <= '0;
        end else if (trap_taken) begin
            epc <= (src == SRC_MISALIGN) ? br_pc : trap_pc;
        end
    end

    // Trap vector, forced word-aligned on write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec <= MTVEC_RESET;
        end else if (mtvec_we) begin
            mtvec <= {mtvec_wdata[PC_WIDTH-1:2], 2'b00};
        end
    end

    // Sanity properties: every trap flushes, and the FSM stays in a legal encoding.
    a_trap_flushes: assert property (@(posedge clk) disable iff (rst)
        trap_taken |-> (flush_if_id && flush_id_ex));
    a_legal_state: assert property (@(posedge clk) disable iff (rst)
        state != 2'd3);

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Bench for pc_next_ctrl: directed scenarios followed by randomized traffic.
// A behavioural model (priority table plus a modelled PC register) predicts every output.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_pc_next_ctrl;

    localparam logic [63:0] RV = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MT = 64'h0000_0000_0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_cur;
    logic        hazard_stall;
    logic        imem_ready;
    logic        br_valid;
    logic [63:0] br_pc;
    logic [63:0] br_target;
    logic        trap_valid;
    logic [63:0] trap_pc;
    logic        mret_valid;
    logic        mtvec_we;
    logic [63:0] mtvec_wdata;
    logic [63:0] pc_next;
    logic        pc_stall;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        fetch_valid;
    logic        trap_taken;
    logic [1:0]  trap_cause;
    logic [63:0] epc;
    logic [63:0] mtvec;

    always #5 clk = ~clk;

    pc_next_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_cur),
        .hazard_stall(hazard_stall),
        .imem_ready  (imem_ready),
        .br_valid    (br_valid),
        .br_pc       (br_pc),
        .br_target   (br_target),
        .trap_valid  (trap_valid),
        .trap_pc     (trap_pc),
        .mret_valid  (mret_valid),
        .mtvec_we    (mtvec_we),
        .mtvec_wdata (mtvec_wdata),
        .pc_next     (pc_next),
        .pc_stall    (pc_stall),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .fetch_valid (fetch_valid),
        .trap_taken  (trap_taken),
        .trap_cause  (trap_cause),
        .epc         (epc),
        .mtvec       (mtvec)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: booting flag, pending flag/target, CSRs and the PC register.
    bit          m_boot;
    bit          m_pend;
    logic [63:0] m_pend_pc;
    logic [63:0] m_epc;
    logic [63:0] m_mtvec;
    logic [63:0] m_pc;

    // DUT outputs sampled at the last falling edge, for directed spot checks.
    logic [63:0] s_next;
    logic        s_stall;
    logic        s_flush;
    logic        s_fv;
    logic        s_tt;
    logic [1:0]  s_cause;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic clear_events();
        br_valid    = 1'b0;
        trap_valid  = 1'b0;
        mret_valid  = 1'b0;
        mtvec_we    = 1'b0;
        hazard_stall = 1'b0;
    endtask

    // One clock: predict and compare combinational outputs, then advance the model.
    task automatic step();
        bit          req [4];
        int          win;
        logic [63:0] tgt;
        logic [63:0] e_next;
        bit          e_stall;
        bit          e_fv;
        bit          e_redir;
        bit          e_tt;
        bit          n_boot;
        bit          n_pend;
        logic [63:0] n_pend_pc;
        logic [63:0] n_epc;
        logic [63:0] n_mtvec;

        @(negedge clk);
        s_next  = pc_next;
        s_stall = pc_stall;
        s_flush = flush_if_id;
        s_fv    = fetch_valid;
        s_tt    = trap_taken;
        s_cause = trap_cause;

        // Lowest index in the request table wins.
        req[0] = trap_valid;
        req[1] = mret_valid;
        req[2] = br_valid && (br_target[1:0] != 2'b00);
        req[3] = br_valid && (br_target[1:0] == 2'b00);
        win = -1;
        for (int i = 3; i >= 0; i--) if (req[i]) win = i;
        if (m_boot) win = -1;
        case (win)
            0, 2:    tgt = m_mtvec;
            1:       tgt = m_epc;
            3:       tgt = br_target;
            default: tgt = pc_cur;
        endcase
        e_redir = (win >= 0);
        e_tt    = (win == 0) || (win == 2);

        n_boot    = 1'b0;
        n_pend    = m_pend;
        n_pend_pc = m_pend_pc;
        e_next    = pc_cur;
        e_stall   = 1'b1;
        e_fv      = 1'b0;
        if (m_boot) begin
            e_next  = RV;
            e_stall = 1'b0;
            n_pend  = 1'b0;
        end else if (!m_pend) begin
            e_fv = 1'b1;
            if (e_redir && imem_ready) begin
                e_next = tgt; e_stall = 1'b0;
            end else if (e_redir) begin
                n_pend = 1'b1; n_pend_pc = tgt;
            end else if (!hazard_stall && imem_ready) begin
                e_next = pc_cur + 64'd4; e_stall = 1'b0;
            end
        end else begin
            if (e_redir) n_pend_pc = tgt;
            if (imem_ready) begin
                e_next = e_redir ? tgt : m_pend_pc;
                e_stall = 1'b0;
                n_pend = 1'b0;
            end
        end

        n_epc = m_epc;
        if (win == 0) n_epc = trap_pc;
        if (win == 2) n_epc = br_pc;
        n_mtvec = mtvec_we ? (mtvec_wdata & ~64'd3) : m_mtvec;

        if (!rst) begin
            check("pc_next", pc_next, e_next);
            check("pc_stall", 64'(pc_stall), 64'(e_stall));
            check("fetch_valid", 64'(fetch_valid), 64'(e_fv));
            check("flush_if_id", 64'(flush_if_id), 64'(e_redir));
            check("flush_id_ex", 64'(flush_id_ex), 64'(e_redir));
            check("trap_taken", 64'(trap_taken), 64'(e_tt));
            if (e_tt) check("trap_cause", 64'(trap_cause), (win == 2) ? 64'd1 : 64'd0);
        end

        @(posedge clk);
        #1;
        if (rst) begin
            m_boot = 1'b1; m_pend = 1'b0; m_pend_pc = '0;
            m_epc = '0; m_mtvec = MT; m_pc = '0;
        end else begin
            m_boot = n_boot; m_pend = n_pend; m_pend_pc = n_pend_pc;
            m_epc = n_epc; m_mtvec = n_mtvec;
            if (!e_stall) m_pc = e_next;
        end
        pc_cur = m_pc;
        check("epc", epc, m_epc);
        check("mtvec", mtvec, m_mtvec);
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; pc_cur = '0;
        br_pc = '0; br_target = '0; trap_pc = '0; mtvec_wdata = '0;
        clear_events();
        m_boot = 1'b1; m_pend = 1'b0; m_pend_pc = '0; m_epc = '0; m_mtvec = MT; m_pc = '0;
        step(); step();
        rst = 1'b0;

        // Boot cycle, then sequential fetch.
        step();
        check("tp1_boot_pc", s_next, RV);
        check("tp1_boot_fv", 64'(s_fv), 64'd0);
        step(); check("tp1_seq1", s_next, 64'h8000_0004);
        step(); check("tp1_seq2", s_next, 64'h8000_0008);
        step(); step();
        check("tp2_pc_cur", pc_cur, 64'h8000_0010);

        // Load-use stall holds the PC.
        hazard_stall = 1'b1;
        step(); check("tp2_stall", 64'(s_stall), 64'd1);
        step(); check("tp2_hold", s_next, 64'h8000_0010);
        check("tp2_noflush", 64'(s_flush), 64'd0);
        hazard_stall = 1'b0;
        step(); check("tp2_resume", s_next, 64'h8000_0014);

        // Branch wins over a hazard stall; misaligned branch traps.
        br_valid = 1'b1; br_target = 64'h8000_0100; br_pc = 64'h8000_0014; hazard_stall = 1'b1;
        step(); check("tp3_br_pc", s_next, 64'h8000_0100);
        check("tp3_br_flush", 64'(s_flush), 64'd1);
        br_target = 64'h8000_0102; br_pc = 64'h8000_0020; hazard_stall = 1'b0;
        step(); check("tp3_mis_pc", s_next, MT);
        check("tp3_mis_cause", 64'(s_cause), 64'd1);
        check("tp3_mis_epc", epc, 64'h8000_0020);

        // Trap beats mret and branch; mret later returns to the trap PC.
        trap_valid = 1'b1; trap_pc = 64'h8000_0040; mret_valid = 1'b1; br_target = 64'h8000_0300;
        step(); check("tp4_trap_pc", s_next, MT);
        check("tp4_trap_tt", 64'(s_tt), 64'd1);
        check("tp4_trap_epc", epc, 64'h8000_0040);
        clear_events();
        step(); check("tp4_tt_pulse", 64'(s_tt), 64'd0);
        mret_valid = 1'b1;
        step(); check("tp4_mret", s_next, 64'h8000_0040);
        clear_events();

        // Redirect parked while imem is busy; a later redirect overwrites it.
        br_valid = 1'b1; br_target = 64'h8000_0200; imem_ready = 1'b0;
        step(); check("tp5_park_stall", 64'(s_stall), 64'd1);
        br_target = 64'h8000_0300;
        step(); check("tp5_pend_fv", 64'(s_fv), 64'd0);
        check("tp5_reflush", 64'(s_flush), 64'd1);
        br_valid = 1'b0;
        step(); check("tp5_pend_stall", 64'(s_stall), 64'd1);
        imem_ready = 1'b1;
        step(); check("tp5_release", s_next, 64'h8000_0300);

        // mtvec write alongside a trap uses the old vector; reset drops a pending redirect.
        mtvec_we = 1'b1; mtvec_wdata = 64'h2003; trap_valid = 1'b1; trap_pc = 64'h8000_0304;
        step(); check("tp6_old_mtvec", s_next, MT);
        check("tp6_new_mtvec", mtvec, 64'h2000);
        clear_events();
        br_valid = 1'b1; br_target = 64'h8000_0500; imem_ready = 1'b0;
        step();
        clear_events(); rst = 1'b1;
        step();
        rst = 1'b0; imem_ready = 1'b1;
        step(); check("tp6_rst_boot", s_next, RV);
        step(); check("tp6_rst_seq", s_next, RV + 64'd4);

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            rst          = ($urandom_range(99) == 0);
            trap_valid   = ($urandom_range(99) < 8);
            mret_valid   = ($urandom_range(99) < 8);
            br_valid     = ($urandom_range(99) < 20);
            hazard_stall = ($urandom_range(99) < 25);
            imem_ready   = ($urandom_range(99) < 70);
            mtvec_we     = ($urandom_range(99) < 5);
            trap_pc      = {$urandom, $urandom};
            br_pc        = {$urandom, $urandom};
            br_target    = {$urandom, $urandom};
            if ($urandom_range(3) != 0) br_target[1:0] = 2'b00;
            mtvec_wdata  = {$urandom, $urandom};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
